// File: rtl/morse_pkg.sv
// Shared Morse definitions: letter codes, element encoding, decoder FSM states
// and the (count, pattern) -> letter lookup.
package morse_pkg;

  localparam logic [2:0] S_CODE = 3'd0;
  localparam logic [2:0] T_CODE = 3'd1;
  localparam logic [2:0] U_CODE = 3'd2;
  localparam logic [2:0] V_CODE = 3'd3;
  localparam logic [2:0] W_CODE = 3'd4;
  localparam logic [2:0] X_CODE = 3'd5;
  localparam logic [2:0] Y_CODE = 3'd6;
  localparam logic [2:0] Z_CODE = 3'd7;

  typedef enum logic { DOT = 1'b0, DASH = 1'b1 } element_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_ERR_WAIT
  } state_e;

  typedef enum logic [1:0] {
    MC_GLITCH,
    MC_DOT,
    MC_DASH
  } mark_class_e;

  // Returns {hit, code}; pat holds the first element in its highest used bit.
  function automatic logic [3:0] morse_lookup(input logic [2:0] cnt,
                                              input logic [3:0] pat);
    logic [3:0] r;
    r = '0;
    case (cnt)
      3'd1: if (pat[0]) r = {1'b1, T_CODE};
      3'd3: begin
        case (pat[2:0])
          3'b000:  r = {1'b1, S_CODE};
          3'b001:  r = {1'b1, U_CODE};
          3'b011:  r = {1'b1, W_CODE};
          default: r = '0;
        endcase
      end
      3'd4: begin
        case (pat)
          4'b0001: r = {1'b1, V_CODE};
          4'b1001: r = {1'b1, X_CODE};
          4'b1011: r = {1'b1, Y_CODE};
          4'b1100: r = {1'b1, Z_CODE};
          default: r = '0;
        endcase
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/morse_run_timer.sv
// Two-flop synchronizer for the Morse line plus a saturating counter of the
// current run length of the synchronized level.
module morse_run_timer #(
  parameter  int unsigned UNIT_CYCLES = 25_000_000,
  localparam int unsigned RUN_W       = $clog2(4 * UNIT_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             morse_in,
  output logic             s,
  output logic             rise,
  output logic             fall,
  output logic [RUN_W-1:0] run_len
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(4 * UNIT_CYCLES);

  logic             sync1_q, sync1_d;
  logic             s_q, s_d;
  logic             s_prev_q, s_prev_d;
  logic [RUN_W-1:0] run_q, run_d;

  always_comb begin
    sync1_d  = morse_in;
    s_d      = sync1_q;
    s_prev_d = s_q;
    // run_q always describes the level currently held in s_q
    if (s_d != s_q)           run_d = RUN_W'(1);
    else if (run_q == RUN_MAX) run_d = run_q;
    else                      run_d = run_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      s_q      <= 1'b0;
      s_prev_q <= 1'b0;
      run_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      s_q      <= s_d;
      s_prev_q <= s_prev_d;
      run_q    <= run_d;
    end
  end

  assign s       = s_q;
  assign rise    = s_q & ~s_prev_q;
  assign fall    = ~s_q & s_prev_q;
  assign run_len = run_q;

endmodule

// File: rtl/morse_decode.sv
// Morse receiver: classifies marks into dots/dashes, groups them into a letter
// and decodes S..Z to a 3-bit code with valid/error pulses.
module morse_decode
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       morse_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       letter_error,
  output logic       busy
);

  localparam int unsigned      RUN_W     = $clog2(4 * UNIT_CYCLES + 1);
  localparam logic [RUN_W-1:0] HALF_UNIT = RUN_W'(UNIT_CYCLES / 2);
  localparam logic [RUN_W-1:0] TWO_UNIT  = RUN_W'(2 * UNIT_CYCLES);
  localparam logic [RUN_W-1:0] FOUR_UNIT = RUN_W'(4 * UNIT_CYCLES);

  logic             s, rise, fall;
  logic [RUN_W-1:0] run_len;

  morse_run_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .morse_in(morse_in),
    .s       (s),
    .rise    (rise),
    .fall    (fall),
    .run_len (run_len)
  );

  state_e      state_q, state_d;
  mark_class_e class_q, class_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  pat_q, pat_d;
  logic [2:0]  letter_q, letter_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic [3:0]  lookup;
  element_e    elem;

  // The run counter restarts on the falling edge, so the mark length is
  // captured as a class one cycle early and consumed when fall is seen.
  always_comb begin
    if (run_len >= TWO_UNIT)       class_d = MC_DASH;
    else if (run_len >= HALF_UNIT) class_d = MC_DOT;
    else                           class_d = MC_GLITCH;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    letter_d = letter_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    lookup   = morse_lookup(cnt_q, pat_q);
    elem     = (class_q == MC_DASH) ? DASH : DOT;

    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_MARK;
      end
      ST_MARK: begin
        if (fall) begin
          if (class_q == MC_GLITCH) begin
            state_d = (cnt_q == 3'd0) ? ST_IDLE : ST_SPACE;
          end else if (cnt_q == 3'd4) begin
            error_d = 1'b1;
            state_d = ST_ERR_WAIT;
          end else begin
            pat_d   = {pat_q[2:0], logic'(elem)};
            cnt_d   = cnt_q + 3'd1;
            state_d = ST_SPACE;
          end
        end else if (run_len == FOUR_UNIT) begin
          error_d = 1'b1;
          state_d = ST_ERR_WAIT;
        end
      end
      ST_SPACE: begin
        if (rise) begin
          state_d = ST_MARK;
        end else if (!s && run_len == TWO_UNIT) begin
          if (lookup[3]) begin
            letter_d = lookup[2:0];
            valid_d  = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          cnt_d   = '0;
          pat_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_ERR_WAIT: begin
        if (!s && run_len == TWO_UNIT) begin
          cnt_d   = '0;
          pat_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      class_q  <= MC_GLITCH;
      cnt_q    <= '0;
      pat_q    <= '0;
      letter_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      class_q  <= class_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign letter       = letter_q;
  assign letter_valid = valid_q;
  assign letter_error = error_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_morse_decode.sv
// Bench for morse_decode (UNIT_CYCLES = 4): directed scenarios plus random
// letters, checked every cycle against a run-length/string-table model.
module tb_morse_decode;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       morse_in;
  logic [2:0] letter;
  logic       letter_valid;
  logic       letter_error;
  logic       busy;

  morse_decode #(.UNIT_CYCLES(U)) dut (
    .clk         (clk),
    .reset       (reset),
    .morse_in    (morse_in),
    .letter      (letter),
    .letter_valid(letter_valid),
    .letter_error(letter_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int    tbl[string];
  int    cyc = 0;
  bit    model_ready = 0;
  bit    sy1, sy2;
  int    run, prev_run;
  string elems;
  bit    marking, flushing;
  int    m_letter;
  bit    m_valid, m_err, m_busy;

  initial begin
    tbl["..."]  = 0; tbl["-"]    = 1; tbl["..-"]  = 2; tbl["...-"] = 3;
    tbl[".--"]  = 4; tbl["-..-"] = 5; tbl["-.--"] = 6; tbl["--.."] = 7;
  end

  always @(posedge clk) begin
    cyc++;
    m_valid = 0;
    m_err   = 0;
    if (reset) begin
      sy1 = 0; sy2 = 0; run = 0; prev_run = 0;
      elems = ""; marking = 0; flushing = 0; m_letter = 0;
    end else begin
      if (sy2 && !marking && !flushing) begin
        marking = 1;
      end else if (marking && !sy2) begin
        marking = 0;
        if (prev_run < U / 2) begin
          // glitch: discarded
        end else if (elems.len() == 4) begin
          m_err = 1; flushing = 1; elems = "";
        end else begin
          elems = {elems, (prev_run >= 2 * U) ? "-" : "."};
        end
      end else if (marking && run >= 4 * U) begin
        m_err = 1; marking = 0; flushing = 1; elems = "";
      end else if (!sy2 && !marking && run == 2 * U && (flushing || elems.len() != 0)) begin
        if (flushing)                flushing = 0;
        else if (tbl.exists(elems)) begin m_valid = 1; m_letter = tbl[elems]; end
        else                         m_err = 1;
        elems = "";
      end
      prev_run = run;
      if (sy1 != sy2)     run = 1;
      else if (run < 4 * U) run++;
      sy2 = sy1;
      sy1 = morse_in;
    end
    m_busy = marking || flushing || (elems.len() != 0);
    model_ready = 1;
  end

  // ---------------- per-cycle compare + pulse bookkeeping ----------------
  int n_valid = 0, n_err = 0, valid_cyc = 0, err_cyc = 0;
  int vq[$];

  always @(negedge clk) begin
    if (model_ready) begin
      chk("letter", 32'(letter), 32'(m_letter));
      chk("letter_valid", 32'(letter_valid), 32'(m_valid));
      chk("letter_error", 32'(letter_error), 32'(m_err));
      chk("busy", 32'(busy), 32'(m_busy));
      if (letter_valid === 1'b1) begin n_valid++; valid_cyc = cyc; vq.push_back(int'(letter)); end
      if (letter_error === 1'b1) begin n_err++; err_cyc = cyc; end
    end
  end

  // ---------------- stimulus ----------------
  int last_fall_edge = 0;

  task automatic mark(input int hi, input int lo);
    morse_in = 1'b1;
    repeat (hi) @(negedge clk);
    morse_in = 1'b0;
    last_fall_edge = cyc + 1;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send(input string code);
    for (int i = 0; i < code.len(); i++)
      mark((code[i] == "-") ? 3 * U : U, (i == code.len() - 1) ? 3 * U : U);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    morse_in = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  string codes[8] = '{"...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

  initial begin
    int nv0, ne0, lt0, rise_edge;
    string c;
    reset = 1'b1;
    morse_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state after a long idle
    repeat (50) @(negedge clk);
    #1;
    chk("idle_letter", 32'(letter), 0);
    chk("idle_valid", 32'(letter_valid), 0);
    chk("idle_error", 32'(letter_error), 0);
    chk("idle_busy", 32'(busy), 0);

    // reset mid-letter after ".", then T
    mark(U, U);
    #1;
    chk("busy_mid_letter", 32'(busy), 1);
    do_reset(2);
    #1;
    chk("busy_after_reset", 32'(busy), 0);
    nv0 = n_valid;
    send("-");
    #1;
    chk("t_after_reset_count", 32'(n_valid - nv0), 1);
    chk("t_after_reset_letter", 32'(letter), 1);

    // T timing: pulse 9 edges after the edge that first samples the low level
    send("-");
    #1;
    chk("t_latency", 32'(valid_cyc - last_fall_edge), 9);

    // Y, then S and Z back to back
    send("-.--");
    #1;
    chk("y_letter", 32'(letter), 6);
    nv0 = n_valid;
    send("...");
    send("--..");
    #1;
    chk("sz_count", 32'(n_valid - nv0), 2);
    if (vq.size() >= 2) begin
      chk("s_code", 32'(vq[vq.size() - 2]), 0);
      chk("z_code", 32'(vq[vq.size() - 1]), 7);
    end else begin
      chk("sz_queue_size", 32'(vq.size()), 2);
    end

    // long mark -> error when the high run reaches 4 units
    nv0 = n_valid;
    ne0 = n_err;
    morse_in = 1'b1;
    rise_edge = cyc + 1;
    repeat (20) @(negedge clk);
    morse_in = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("long_err_count", 32'(n_err - ne0), 1);
    chk("long_err_latency", 32'(err_cyc - rise_edge), 17);
    chk("long_no_valid", 32'(n_valid - nv0), 0);
    send(".--");
    #1;
    chk("w_letter", 32'(letter), 4);

    // A is unknown: error, letter held
    ne0 = n_err;
    lt0 = int'(letter);
    send(".-");
    #1;
    chk("a_err_count", 32'(n_err - ne0), 1);
    chk("a_letter_held", 32'(letter), 32'(lt0));

    // five dots: error on the fifth fall
    ne0 = n_err;
    send(".....");
    #1;
    chk("five_dot_err", 32'(n_err - ne0), 1);
    chk("five_dot_latency", 32'(err_cyc - last_fall_edge), 2);

    // glitches in idle and inside a space, then X
    ne0 = n_err;
    nv0 = n_valid;
    mark(1, 10);
    #1;
    chk("idle_glitch_busy", 32'(busy), 0);
    mark(3 * U, 2);
    mark(1, 2);
    mark(U, U);
    mark(U, U);
    mark(3 * U, 3 * U);
    #1;
    chk("x_letter", 32'(letter), 5);
    chk("x_no_err", 32'(n_err - ne0), 0);
    chk("x_one_valid", 32'(n_valid - nv0), 1);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 14) == 0) do_reset($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 0) begin
        c = codes[$urandom_range(0, 7)];
        for (int i = 0; i < c.len(); i++)
          mark((c[i] == "-") ? $urandom_range(2 * U, 4 * U - 1) : $urandom_range(U / 2, 2 * U - 1),
               (i == c.len() - 1) ? $urandom_range(2 * U, 3 * U + 2) : $urandom_range(1, 2 * U - 1));
      end else begin
        int n;
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) begin
          int hi;
          if ($urandom_range(0, 7) == 0) mark(1, $urandom_range(1, 3));
          case ($urandom_range(0, 9))
            0:       hi = $urandom_range(4 * U, 5 * U + 2);
            1, 2, 3: hi = $urandom_range(U / 2, 2 * U - 1);
            default: hi = $urandom_range(2 * U, 4 * U - 1);
          endcase
          mark(hi, (i == n - 1) ? $urandom_range(2 * U, 3 * U + 2) : $urandom_range(1, 2 * U - 1));
        end
      end
    end
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
